// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default
// geometry and the MEM-stage opcodes whose decode drives mem_read/mem_write.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  // RV32-style major opcodes that the control path turns into mem_read/mem_write
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port synchronous word RAM with registered read; contents survive reset.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: latches one request, waits WAIT_CYCLES,
// performs the access and stalls the pipeline until the RESP cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              stall,
  output logic              err
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              op_write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  logic              req;
  logic              latch;
  logic              commit;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign req = mem_read ^ mem_write;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch      = 1'b0;
    commit     = 1'b0;
    stall      = 1'b0;
    rvalid     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          latch = 1'b1;
          stall = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_reg == '0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        rvalid     = ~op_write_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A zero-wait access commits on the accept edge, before the latch is visible.
  assign acc_write = (state_reg == IDLE) ? mem_write : op_write_reg;
  assign acc_addr  = (state_reg == IDLE) ? addr      : addr_reg;
  assign acc_wdata = (state_reg == IDLE) ? wdata     : wdata_reg;
  assign ram_we    = commit & acc_write & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_write_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= (state_reg == IDLE) && mem_read && mem_write;
      if (latch) begin
        op_write_reg <= mem_write;
        addr_reg     <= addr;
        wdata_reg    <= wdata;
      end
      if (rvalid) begin
        rdata_reg <= ram_rdata;
      end
    end
  end

  // The RAM output register already holds the word during RESP; afterwards rdata_reg keeps it.
  assign rdata = rvalid ? ram_rdata : rdata_reg;
  assign err   = err_reg;

  dmem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (acc_addr),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance and a zero-wait instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [7:0]  a0 = '0, a1 = '0;
  logic [15:0] wd0 = '0, wd1 = '0;
  logic [15:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, stall0, stall1, err0, err1;

  dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .addr(a0), .wdata(wd0),
    .rdata(rdata0), .rvalid(rvalid0), .stall(stall0), .err(err0)
  );

  dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .addr(a1), .wdata(wd1),
    .rdata(rdata1), .rvalid(rvalid1), .stall(stall1), .err(err1)
  );

  // op: 1 read, 2 write, 3 read+write; flag: 0 none, 1 change inputs in BUSY, 2 reset in 2nd BUSY
  typedef struct packed {
    logic        dut;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    logic [1:0]  flag;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_rd[$];
  int          exp_stall[$];
  int          exp_err[$];
  logic        done = 1'b0;
  logic        rst_q = 1'b1;

  int checks = 0;
  int errors = 0;

  always @(posedge clk) rst_q <= rst;

  task automatic set_inputs(input logic d, input logic r, input logic w,
                            input logic [7:0] a, input logic [15:0] wd);
    if (d == 1'b0) begin
      rd0 = r; wr0 = w; a0 = a; wd0 = wd;
    end else begin
      rd1 = r; wr1 = w; a1 = a; wd1 = wd;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    w = v.dut ? 0 : 2;
    if (v.op == 2'd3) exp_err.push_back(1);
    else exp_stall.push_back(1 + w);
    if (v.op == 2'd1) exp_rd.push_back(v.exp);
    set_inputs(v.dut, v.op[0], v.op[1], v.addr, v.wdata);
    @(posedge clk); #1;
    if (v.flag == 2'd1) set_inputs(v.dut, 1'b0, 1'b0, v.addr + 8'd1, 16'hFFFF);
    else set_inputs(v.dut, 1'b0, 1'b0, v.addr, v.wdata);
    if (v.flag == 2'd2) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
    end else begin
      repeat (1 + w) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs.push_back('{1'b0, 2'd2, 8'h10, 16'hBEEF, 16'h0000, 2'd0});
    vecs.push_back('{1'b0, 2'd1, 8'h10, 16'h0000, 16'hBEEF, 2'd0});
    vecs.push_back('{1'b0, 2'd2, 8'h40, 16'h1111, 16'h0000, 2'd0});
    vecs.push_back('{1'b0, 2'd3, 8'h40, 16'h2222, 16'h0000, 2'd0});
    vecs.push_back('{1'b0, 2'd1, 8'h40, 16'h0000, 16'h1111, 2'd0});
    vecs.push_back('{1'b0, 2'd2, 8'h21, 16'h5555, 16'h0000, 2'd0});
    vecs.push_back('{1'b0, 2'd2, 8'h20, 16'h1234, 16'h0000, 2'd1});
    vecs.push_back('{1'b0, 2'd1, 8'h20, 16'h0000, 16'h1234, 2'd0});
    vecs.push_back('{1'b0, 2'd1, 8'h21, 16'h0000, 16'h5555, 2'd0});
    vecs.push_back('{1'b0, 2'd2, 8'h30, 16'h7777, 16'h0000, 2'd0});
    vecs.push_back('{1'b0, 2'd2, 8'h30, 16'hAAAA, 16'h0000, 2'd2});
    vecs.push_back('{1'b0, 2'd1, 8'h30, 16'h0000, 16'h7777, 2'd0});
    vecs.push_back('{1'b1, 2'd2, 8'hFF, 16'h5A5A, 16'h0000, 2'd0});
    vecs.push_back('{1'b1, 2'd1, 8'hFF, 16'h0000, 16'h5A5A, 2'd0});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    foreach (vecs[i]) run_vec(vecs[i]);
    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

  // Monitor: pops expectations whenever an instance presents a stall burst, err pulse or read response.
  logic        o_stall[2], o_rv[2], o_err[2], prev_stall[2];
  logic [15:0] o_rdata[2], hold[2];
  int          stall_run[2], err_run[2], rv_run[2];
  int          e_len;
  logic [15:0] e_data;

  initial begin
    for (int d = 0; d < 2; d++) begin
      prev_stall[d] = 1'b0; hold[d] = '0;
      stall_run[d] = 0; err_run[d] = 0; rv_run[d] = 0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      o_stall[0] = stall0; o_rv[0] = rvalid0; o_err[0] = err0; o_rdata[0] = rdata0;
      o_stall[1] = stall1; o_rv[1] = rvalid1; o_err[1] = err1; o_rdata[1] = rdata1;
      for (int d = 0; d < 2; d++) begin
        if (o_stall[d] === 1'b1) stall_run[d]++;
        else if (stall_run[d] > 0) begin
          checks++;
          if (exp_stall.size() == 0) begin
            errors++;
            $display("FAIL stall_len dut%0d: got %0d cycles, required none", d, stall_run[d]);
          end else begin
            e_len = exp_stall.pop_front();
            if (stall_run[d] != e_len) begin
              errors++;
              $display("FAIL stall_len dut%0d: got %0d cycles, required %0d", d, stall_run[d], e_len);
            end
          end
          stall_run[d] = 0;
        end
        if (o_err[d] === 1'b1) err_run[d]++;
        else if (err_run[d] > 0) begin
          checks++;
          if (exp_err.size() == 0) begin
            errors++;
            $display("FAIL err_pulse dut%0d: got %0d cycles, required none", d, err_run[d]);
          end else begin
            e_len = exp_err.pop_front();
            if (err_run[d] != e_len) begin
              errors++;
              $display("FAIL err_pulse dut%0d: got %0d cycles, required %0d", d, err_run[d], e_len);
            end
          end
          err_run[d] = 0;
        end
        if (rst_q) begin
          checks++;
          if (o_stall[d] !== 1'b0 || o_rv[d] !== 1'b0 || o_err[d] !== 1'b0 || o_rdata[d] !== 16'h0) begin
            errors++;
            $display("FAIL reset_state dut%0d: stall=%b rvalid=%b err=%b rdata=%h, required 0/0/0/0000",
                     d, o_stall[d], o_rv[d], o_err[d], o_rdata[d]);
          end
          hold[d] = '0;
        end
        if (o_rv[d] === 1'b1) begin
          rv_run[d]++;
          checks++;
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL read_data dut%0d: got %h, required no response", d, o_rdata[d]);
          end else begin
            e_data = exp_rd.pop_front();
            if (o_rdata[d] !== e_data) begin
              errors++;
              $display("FAIL read_data dut%0d: got %h, required %h", d, o_rdata[d], e_data);
            end
          end
          checks++;
          if (o_stall[d] !== 1'b0 || prev_stall[d] !== 1'b1) begin
            errors++;
            $display("FAIL resp_timing dut%0d: stall=%b prev_stall=%b, required 0/1", d, o_stall[d], prev_stall[d]);
          end
          hold[d] = o_rdata[d];
        end else begin
          if (rv_run[d] > 0) begin
            checks++;
            if (rv_run[d] != 1) begin
              errors++;
              $display("FAIL rvalid_len dut%0d: got %0d cycles, required 1", d, rv_run[d]);
            end
            rv_run[d] = 0;
          end
          checks++;
          if (o_rdata[d] !== hold[d]) begin
            errors++;
            $display("FAIL rdata_hold dut%0d: got %h, required %h", d, o_rdata[d], hold[d]);
          end
        end
        prev_stall[d] = o_stall[d];
      end
      $display("cycle t=%0t dut0 stall=%b rvalid=%b err=%b rdata=%h | dut1 stall=%b rvalid=%b err=%b rdata=%h",
               $time, stall0, rvalid0, err0, rdata0, stall1, rvalid1, err1, rdata1);
      if (done) break;
    end
    checks++;
    if (exp_rd.size() != 0 || exp_stall.size() != 0 || exp_err.size() != 0) begin
      errors++;
      $display("FAIL leftover: got rd=%0d stall=%0d err=%0d pending, required 0/0/0",
               exp_rd.size(), exp_stall.size(), exp_err.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
